// File: rtl/VX_tcu_pkg.sv
// Shared types and defaults for the TCU dispatch sequencer.
// step_bits() sizes the step field, never narrower than one bit.
package VX_tcu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } tcu_seq_state_e;

    localparam int TCU_MAX_STEPS       = 4;
    localparam int TCU_MAX_OUTSTANDING = 4;
    localparam int TCU_NUM_LANES       = 4;
    localparam int TCU_NW_BITS         = 4;

    function automatic int step_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_tcu_credit_counter.sv
// Purpose: up/down saturating credit pool, initialised full; inc+dec in one cycle is net zero.
// Latency: count updates on the clock edge after inc/dec; empty/full are registered-count decodes.
// Backpressure: none; an inc while full saturates and trips a simulation assertion.
module vx_tcu_credit_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic empty,
    output logic full
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= MAX_V;
        end else if (inc && !dec && !full) begin
            count <= count + ONE;
        end else if (dec && !inc && !empty) begin
            count <= count - ONE;
        end
    end

    assign empty = (count == '0);
    assign full  = (count == MAX_V);

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!reset) !(inc && !dec && full))
        else $error("credit return with pool already full");
`endif

endmodule

// File: rtl/vx_tcu_dispatch_seq.sv
// Purpose: splits one tile-MMA instruction into step-tagged dispatch beats, credit-limited by eop commits.
// Latency: accept at N -> step 0 at N+1, last step at N+nsteps with out_ready high; back-to-back with no bubble.
// Backpressure: out_* held stable while stalled; in_ready needs a credit and idle or a final-beat fire. TCU_DISPATCH_PERF_EN adds stall counters.
module vx_tcu_dispatch_seq
    import VX_tcu_pkg::*;
#(
    parameter int NUM_LANES       = TCU_NUM_LANES,
    parameter int NW_BITS         = TCU_NW_BITS,
    parameter int MAX_STEPS       = TCU_MAX_STEPS,
    parameter int MAX_OUTSTANDING = TCU_MAX_OUTSTANDING,
    parameter int STEP_BITS       = step_bits(MAX_STEPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NW_BITS-1:0]        in_wid,
    input  logic [NUM_LANES-1:0]      in_tmask,
    input  logic [31:0]               in_pc,
    input  logic [4:0]                in_rd,
    input  logic [43:0]               in_uuid,
    input  logic [STEP_BITS:0]        in_steps,
    input  logic [NUM_LANES*32-1:0]   in_rs1,
    input  logic [NUM_LANES*32-1:0]   in_rs2,
    input  logic [NUM_LANES*32-1:0]   in_rs3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NW_BITS-1:0]        out_wid,
    output logic [NUM_LANES-1:0]      out_tmask,
    output logic [31:0]               out_pc,
    output logic [4:0]                out_rd,
    output logic [43:0]               out_uuid,
    output logic [NUM_LANES*32-1:0]   out_rs1,
    output logic [NUM_LANES*32-1:0]   out_rs2,
    output logic [NUM_LANES*32-1:0]   out_rs3,
    output logic [STEP_BITS-1:0]      out_step,
    output logic                      out_sop,
    output logic                      out_eop,
    input  logic                      cmt_valid,
    input  logic                      cmt_eop,
    output logic                      busy
`ifdef TCU_DISPATCH_PERF_EN
    ,
    output logic [43:0]               perf_stall_cycles,
    output logic [43:0]               perf_credit_stall
`endif
);

    localparam int SW = STEP_BITS + 1;
    localparam logic [STEP_BITS:0]   MAXS = SW'(MAX_STEPS);
    localparam logic [STEP_BITS:0]   NONE = SW'(1);
    localparam logic [STEP_BITS-1:0] SONE = STEP_BITS'(1);

    typedef struct packed {
        logic [NW_BITS-1:0]      wid;
        logic [NUM_LANES-1:0]    tmask;
        logic [31:0]             pc;
        logic [4:0]              rd;
        logic [43:0]             uuid;
        logic [NUM_LANES*32-1:0] rs1;
        logic [NUM_LANES*32-1:0] rs2;
        logic [NUM_LANES*32-1:0] rs3;
    } hdr_t;

    tcu_seq_state_e       state, state_n;
    logic [STEP_BITS-1:0] step, step_n;
    logic [STEP_BITS:0]   nsteps, nsteps_n, steps_clamped;
    logic                 sop_q, sop_n, eop_q, eop_n;
    hdr_t                 hdr_q, hdr_n, hdr_in;
    logic                 take, out_fire, cred_empty, cred_full;

    assign hdr_in   = {in_wid, in_tmask, in_pc, in_rd, in_uuid, in_rs1, in_rs2, in_rs3};
    assign out_fire = (state == SEQ) && out_ready;
    assign in_ready = reset && !cred_empty && ((state == IDLE) || (out_fire && eop_q));
    // An all-zero thread mask is accepted but swallowed: no beats, no credit.
    assign take     = in_valid && in_ready && (in_tmask != '0);

    always_comb begin
        steps_clamped = in_steps;
        if (in_steps == '0) begin
            steps_clamped = NONE;
        end else if (in_steps > MAXS) begin
            steps_clamped = MAXS;
        end
    end

    always_comb begin
        state_n  = state;
        step_n   = step;
        nsteps_n = nsteps;
        hdr_n    = hdr_q;
        if (out_fire) begin
            if (eop_q) begin
                state_n = IDLE;
            end else begin
                step_n = step + SONE;
            end
        end
        if (take) begin
            state_n  = SEQ;
            step_n   = '0;
            nsteps_n = steps_clamped;
            hdr_n    = hdr_in;
        end
        sop_n = (state_n == SEQ) && (step_n == '0);
        eop_n = (state_n == SEQ) && ({1'b0, step_n} == (nsteps_n - NONE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            step   <= '0;
            nsteps <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            hdr_q  <= '0;
        end else begin
            state  <= state_n;
            step   <= step_n;
            nsteps <= nsteps_n;
            sop_q  <= sop_n;
            eop_q  <= eop_n;
            hdr_q  <= hdr_n;
        end
    end

    vx_tcu_credit_counter #(
        .MAX (MAX_OUTSTANDING)
    ) credit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (cmt_valid && cmt_eop),
        .dec   (take),
        .empty (cred_empty),
        .full  (cred_full)
    );

    assign out_valid = (state == SEQ);
    assign out_step  = step;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_wid   = hdr_q.wid;
    assign out_tmask = hdr_q.tmask;
    assign out_pc    = hdr_q.pc;
    assign out_rd    = hdr_q.rd;
    assign out_uuid  = hdr_q.uuid;
    assign out_rs1   = hdr_q.rs1;
    assign out_rs2   = hdr_q.rs2;
    assign out_rs3   = hdr_q.rs3;
    assign busy      = (state == SEQ) || !cred_full;

`ifdef TCU_DISPATCH_PERF_EN
    logic [43:0] stall_cnt, credit_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            credit_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt <= stall_cnt + 44'd1;
            if (in_valid && cred_empty)  credit_cnt <= credit_cnt + 44'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt;
    assign perf_credit_stall = credit_cnt;
`endif

endmodule

// File: tb/tb_vx_tcu_dispatch_seq.sv
// Scoreboard bench for vx_tcu_dispatch_seq, built with a two-credit pool.
// Expected beats are queued on accept and popped on every out fire.
module tb_vx_tcu_dispatch_seq;
    import VX_tcu_pkg::*;

    localparam int NL  = 4;
    localparam int NWB = 4;
    localparam int MS  = 4;
    localparam int MO  = 2;
    localparam int SB  = step_bits(MS);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid, in_ready;
    logic [NWB-1:0]    in_wid;
    logic [NL-1:0]     in_tmask;
    logic [31:0]       in_pc;
    logic [4:0]        in_rd;
    logic [43:0]       in_uuid;
    logic [SB:0]       in_steps;
    logic [NL*32-1:0]  in_rs1, in_rs2, in_rs3;
    logic              out_valid, out_ready;
    logic [NWB-1:0]    out_wid;
    logic [NL-1:0]     out_tmask;
    logic [31:0]       out_pc;
    logic [4:0]        out_rd;
    logic [43:0]       out_uuid;
    logic [NL*32-1:0]  out_rs1, out_rs2, out_rs3;
    logic [SB-1:0]     out_step;
    logic              out_sop, out_eop;
    logic              cmt_valid, cmt_eop, busy;
`ifdef TCU_DISPATCH_PERF_EN
    logic [43:0]       perf_stall_cycles, perf_credit_stall;
`endif

    always #5 clk = ~clk;

    vx_tcu_dispatch_seq #(
        .NUM_LANES(NL), .NW_BITS(NWB), .MAX_STEPS(MS), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_tmask(in_tmask),
        .in_pc(in_pc), .in_rd(in_rd), .in_uuid(in_uuid), .in_steps(in_steps),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_tmask(out_tmask),
        .out_pc(out_pc), .out_rd(out_rd), .out_uuid(out_uuid),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_step(out_step), .out_sop(out_sop), .out_eop(out_eop),
        .cmt_valid(cmt_valid), .cmt_eop(cmt_eop), .busy(busy)
`ifdef TCU_DISPATCH_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles), .perf_credit_stall(perf_credit_stall)
`endif
    );

    typedef struct {
        int               step;
        bit               sop, eop;
        logic [NWB-1:0]   wid;
        logic [NL-1:0]    tmask;
        logic [31:0]      pc;
        logic [4:0]       rd;
        logic [43:0]      uuid;
        logic [NL*32-1:0] rs1, rs2, rs3;
        int               cyc;
    } beat_t;

    beat_t sb[$];
    beat_t e;
    int    ncmp = 0, nerr = 0, cyc = 0, nbeats = 0, npushed = 0, outstanding = 0;
    bit    prev_stall = 0;
    logic [SB-1:0]    snap_step;
    logic             snap_sop, snap_eop;
    logic [31:0]      snap_pc;
    logic [NL*32-1:0] snap_rs3;
    bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (prev_stall) begin
            chk("hold_vld", out_valid, 1);
            chk("hold_step", out_step, snap_step);
            chk("hold_sop_eop", {out_sop, out_eop}, {snap_sop, snap_eop});
            chk("hold_pc", out_pc, snap_pc);
            chk("hold_rs3", out_rs3, snap_rs3);
        end
        prev_stall = out_valid && !out_ready && reset;
        snap_step = out_step; snap_sop = out_sop; snap_eop = out_eop;
        snap_pc = out_pc; snap_rs3 = out_rs3;
        if (out_valid && out_ready) begin
            nbeats++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("step", out_step, e.step);
                chk("sop", out_sop, e.sop);
                chk("eop", out_eop, e.eop);
                chk("wid_tmask_rd", {out_wid, out_tmask, out_rd}, {e.wid, e.tmask, e.rd});
                chk("pc", out_pc, e.pc);
                chk("uuid", out_uuid, e.uuid);
                chk("rs1", out_rs1, e.rs1);
                chk("rs2", out_rs2, e.rs2);
                chk("rs3", out_rs3, e.rs3);
                chk("busy_in_seq", busy, 1);
                if (e.cyc >= 0) chk("beat_cyc", cyc, e.cyc);
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [NWB-1:0] wid, input logic [NL-1:0] tmask,
                        input logic [SB:0] steps, input bit timed, output int waited);
        int    n;
        bit    ok;
        beat_t b;
        in_wid = wid; in_tmask = tmask; in_steps = steps;
        in_pc = $urandom; in_rd = 5'($urandom); in_uuid = {12'($urandom), $urandom};
        in_rs1 = {$urandom, $urandom, $urandom, $urandom};
        in_rs2 = {$urandom, $urandom, $urandom, $urandom};
        in_rs3 = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        waited = 0;
        ok = 0;
        while (!ok && waited < 40) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else waited++;
        end
        if (!ok) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        if (tmask != '0) begin
            n = (steps == 0) ? 1 : ((int'(steps) > MS) ? MS : int'(steps));
            for (int k = 0; k < n; k++) begin
                b.step = k; b.sop = (k == 0); b.eop = (k == n - 1);
                b.wid = in_wid; b.tmask = in_tmask; b.pc = in_pc; b.rd = in_rd; b.uuid = in_uuid;
                b.rs1 = in_rs1; b.rs2 = in_rs2; b.rs3 = in_rs3;
                b.cyc = timed ? cyc + 1 + k : -1;
                sb.push_back(b);
            end
            npushed += n;
            outstanding++;
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic commit();
        cmt_valid = 1'b1; cmt_eop = 1'b1;
        @(posedge clk); #2;
        cmt_valid = 1'b0; cmt_eop = 1'b0;
        outstanding--;
    endtask

    task automatic wait_sb();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk); #2;
    endtask

    task automatic drain();
        wait_sb();
        while (outstanding > 0) commit();
    endtask

    int w;
`ifdef TCU_DISPATCH_PERF_EN
    logic [43:0] stall_base;
`endif

    initial begin
        in_valid = 0; in_wid = '0; in_tmask = '0; in_pc = '0; in_rd = '0; in_uuid = '0;
        in_steps = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
        out_ready = 1; cmt_valid = 0; cmt_eop = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sop_eop_step", {out_sop, out_eop, out_step}, 0);
        chk("rst_pc_uuid", {out_pc, out_uuid}, 0);
        chk("rst_rs1", out_rs1, 0);
        @(posedge clk); #2;
        reset = 1;

        // single instruction, 4 steps; busy held until its commit
        send(4'h3, 4'hF, 3'd4, 1, w);
        wait_sb();
        @(negedge clk);
        chk("busy_until_cmt", busy, 1);
        @(posedge clk); #2;
        commit();
        @(negedge clk);
        chk("busy_after_cmt", busy, 0);
        @(posedge clk); #2;

        // back-to-back, 2 steps each
        send(4'h1, 4'hF, 3'd2, 1, w);
        send(4'h2, 4'h5, 3'd2, 1, w);
        chk("b2b_wait", w, 1);
        drain();

        // credit exhaustion and return
        send(4'h4, 4'h1, 3'd1, 1, w);
        send(4'h5, 4'h2, 3'd1, 1, w);
        fork
            send(4'h6, 4'hF, 3'd2, 1, w);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("credit_stall_rdy", in_ready, 0);
                end
                @(posedge clk); #2;
                commit();
                @(negedge clk);
                chk("rdy_after_cmt", in_ready, 1);
            end
        join
        drain();

        // out_ready 1,0,0,1 during a 3-step sequence
`ifdef TCU_DISPATCH_PERF_EN
        stall_base = perf_stall_cycles;
`endif
        send(4'h7, 4'hA, 3'd3, 0, w);
        for (int i = 0; i < 4; i++) begin
            out_ready = pat[i];
            @(posedge clk); #2;
        end
        out_ready = 1;
        drain();
`ifdef TCU_DISPATCH_PERF_EN
        chk("perf_stall", perf_stall_cycles - stall_base, 2);
`endif

        // dropped instruction, zero and oversized step counts
        send(4'h8, 4'h0, 3'd2, 1, w);
        repeat (3) begin
            @(negedge clk);
            chk("drop_no_vld", out_valid, 0);
        end
        chk("drop_credit", busy, 0);
        @(posedge clk); #2;
        send(4'h9, 4'h3, 3'd0, 1, w);
        send(4'hA, 4'hF, 3'd7, 1, w);
        drain();

        // asynchronous reset mid-sequence
        send(4'hB, 4'hF, 3'd4, 1, w);
        @(posedge clk); #2;
        chk("pre_rst_step", out_step, 1);
        reset = 0;
        #1;
        chk("rst_abort_vld", out_valid, 0);
        chk("rst_abort_rdy", in_ready, 0);
        npushed -= sb.size();
        sb.delete();
        outstanding = 0;
        @(negedge clk);
        chk("rst_abort_busy", busy, 0);
        @(posedge clk); #2;
        reset = 1;
        send(4'hC, 4'h9, 3'd2, 1, w);
        chk("post_rst_wait", w, 0);
        drain();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("beat_count", nbeats, npushed);
        chk("final_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
